// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: a circular byte FIFO drained back-to-back onto the serial line.
// Frame format (parity, stop bits) is fixed at build time; baud rate is latched per frame.
module uart_tx_fifo #(
  parameter int unsigned CLK_FREQ   = 50_000_000,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned PARITY_EN  = 0,
  parameter int unsigned PARITY_ODD = 0,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic                          Clk,
  input  logic                          Rst_n,
  input  logic [2:0]                    baud_set,
  input  logic                          wr_en,
  input  logic [7:0]                    wr_data,
  output logic                          full,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  output logic                          Rs232_Tx,
  output logic                          tx_busy,
  output logic                          Tx_Done
);

  localparam int unsigned PtrW   = $clog2(FIFO_DEPTH);
  localparam int unsigned LevelW = PtrW + 1;

  localparam int unsigned Div9600   = CLK_FREQ / 9600 - 1;
  localparam int unsigned Div19200  = CLK_FREQ / 19200 - 1;
  localparam int unsigned Div38400  = CLK_FREQ / 38400 - 1;
  localparam int unsigned Div57600  = CLK_FREQ / 57600 - 1;
  localparam int unsigned Div115200 = CLK_FREQ / 115200 - 1;

  // The slowest rate has the largest divider, so it sets the counter width.
  localparam int unsigned DivW = ($clog2(CLK_FREQ / 9600) > 0) ? $clog2(CLK_FREQ / 9600) : 1;

  localparam logic LastStop = (STOP_BITS == 2);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } state_e;

  state_e state_q, state_d;

  logic [DivW-1:0]   baud_cnt_q, baud_cnt_d;
  logic [DivW-1:0]   div_q, div_d;
  logic [DivW-1:0]   div_sel;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic              stop_cnt_q, stop_cnt_d;
  logic [7:0]        shift_q, shift_d;
  logic              parity_q, parity_d;
  logic              tx_q, tx_d;
  logic              done_q, done_d;
  logic              ovf_q, ovf_d;

  logic [7:0]        mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LevelW-1:0] level_q, level_d;

  logic              push;
  logic              pop;
  logic              start_frame;
  logic              bit_end;
  logic              fifo_empty;
  logic              fifo_full;
  logic [7:0]        head;

  always_comb begin
    case (baud_set)
      3'd0:    div_sel = DivW'(Div9600);
      3'd1:    div_sel = DivW'(Div19200);
      3'd2:    div_sel = DivW'(Div38400);
      3'd3:    div_sel = DivW'(Div57600);
      default: div_sel = DivW'(Div115200);
    endcase
  end

  assign fifo_empty = (level_q == '0);
  assign fifo_full  = (level_q == LevelW'(FIFO_DEPTH));
  assign head       = mem_q[rd_ptr_q];
  assign bit_end    = (baud_cnt_q == div_q);

  // Fullness is judged on the registered level, so a pop in the same cycle cannot make room.
  assign push  = wr_en && !fifo_full;
  assign ovf_d = wr_en && fifo_full;

  always_comb begin
    state_d     = state_q;
    baud_cnt_d  = bit_end ? '0 : baud_cnt_q + DivW'(1);
    div_d       = div_q;
    bit_cnt_d   = bit_cnt_q;
    stop_cnt_d  = stop_cnt_q;
    shift_d     = shift_q;
    parity_d    = parity_q;
    tx_d        = tx_q;
    done_d      = 1'b0;
    pop         = 1'b0;
    start_frame = 1'b0;

    unique case (state_q)
      StIdle: begin
        baud_cnt_d = '0;
        if (!fifo_empty) start_frame = 1'b1;
      end
      StStart: begin
        if (bit_end) begin
          state_d   = StData;
          tx_d      = shift_q[0];
          bit_cnt_d = '0;
        end
      end
      StData: begin
        if (bit_end) begin
          if (bit_cnt_q == 3'd7) begin
            if (PARITY_EN != 0) begin
              state_d = StParity;
              tx_d    = parity_q;
            end else begin
              state_d    = StStop;
              tx_d       = 1'b1;
              stop_cnt_d = 1'b0;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            shift_d   = {1'b0, shift_q[7:1]};
            tx_d      = shift_q[1];
          end
        end
      end
      StParity: begin
        if (bit_end) begin
          state_d    = StStop;
          tx_d       = 1'b1;
          stop_cnt_d = 1'b0;
        end
      end
      StStop: begin
        if (bit_end) begin
          if (stop_cnt_q == LastStop) begin
            done_d = 1'b1;
            if (!fifo_empty) start_frame = 1'b1;
            else state_d = StIdle;
          end else begin
            stop_cnt_d = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // Shared by the idle launch and the gapless stop-to-start chain.
    if (start_frame) begin
      pop        = 1'b1;
      state_d    = StStart;
      shift_d    = head;
      parity_d   = (PARITY_ODD != 0) ? ~^head : ^head;
      div_d      = div_sel;
      baud_cnt_d = '0;
      bit_cnt_d  = '0;
      tx_d       = 1'b0;
    end
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
    unique case ({push, pop})
      2'b10:   level_d = level_q + LevelW'(1);
      2'b01:   level_d = level_q - LevelW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data;
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state_q    <= StIdle;
      baud_cnt_q <= '0;
      div_q      <= '0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      shift_q    <= '0;
      parity_q   <= 1'b0;
      tx_q       <= 1'b1;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
    end else begin
      state_q    <= state_d;
      baud_cnt_q <= baud_cnt_d;
      div_q      <= div_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      shift_q    <= shift_d;
      parity_q   <= parity_d;
      tx_q       <= tx_d;
      done_q     <= done_d;
      ovf_q      <= ovf_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
    end
  end

  assign full       = fifo_full;
  assign fifo_level = level_q;
  assign overflow   = ovf_q;
  assign Rs232_Tx   = tx_q;
  assign tx_busy    = (state_q != StIdle);
  assign Tx_Done    = done_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: a queue-based cycle model checks one instance every cycle,
// with table-driven frame vectors and directed corner sequences on top.
module tb_uart_tx_fifo;

  // 1.152 MHz gives exact, short bit periods: 120/60/30/20/10 cycles.
  localparam int unsigned AClk   = 1_152_000;
  localparam int unsigned ADepth = 16;

  logic Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic       Rst_n;
  logic [2:0] a_baud, b_baud;
  logic       a_wr_en, b_wr_en;
  logic [7:0] a_wr_data, b_wr_data;
  logic       a_full, a_ovf, a_tx, a_busy, a_done;
  logic [4:0] a_level;
  logic       b_full, b_ovf, b_tx, b_busy, b_done;
  logic [2:0] b_level;

  int checks = 0;
  int errors = 0;

  uart_tx_fifo #(
    .CLK_FREQ  (AClk),
    .FIFO_DEPTH(ADepth)
  ) dut_a (
    .Clk       (Clk),
    .Rst_n     (Rst_n),
    .baud_set  (a_baud),
    .wr_en     (a_wr_en),
    .wr_data   (a_wr_data),
    .full      (a_full),
    .fifo_level(a_level),
    .overflow  (a_ovf),
    .Rs232_Tx  (a_tx),
    .tx_busy   (a_busy),
    .Tx_Done   (a_done)
  );

  uart_tx_fifo #(
    .CLK_FREQ  (50_000_000),
    .FIFO_DEPTH(4),
    .PARITY_EN (1),
    .PARITY_ODD(1),
    .STOP_BITS (2)
  ) dut_b (
    .Clk       (Clk),
    .Rst_n     (Rst_n),
    .baud_set  (b_baud),
    .wr_en     (b_wr_en),
    .wr_data   (b_wr_data),
    .full      (b_full),
    .fifo_level(b_level),
    .overflow  (b_ovf),
    .Rs232_Tx  (b_tx),
    .tx_busy   (b_busy),
    .Tx_Done   (b_done)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  function automatic logic line(input bit sel);
    return sel ? b_tx : a_tx;
  endfunction

  function automatic logic done(input bit sel);
    return sel ? b_done : a_done;
  endfunction

  function automatic int period_of(input logic [2:0] b);
    case (b)
      3'd0:    return AClk / 9600;
      3'd1:    return AClk / 19200;
      3'd2:    return AClk / 38400;
      3'd3:    return AClk / 57600;
      default: return AClk / 115200;
    endcase
  endfunction

  // ---------------- reference model of dut_a ----------------
  logic       s_rst = 1'b0;
  logic       s_wr = 1'b0;
  logic [7:0] s_data = 8'h00;
  logic [2:0] s_baud = 3'd0;
  logic [7:0] m_q[$];
  bit         m_in = 0;
  bit         m_done = 0;
  bit         m_ovf = 0;
  int         m_cyc = 0;
  int         m_period = 1;
  logic [9:0] m_bits = '1;
  int         m_sz;
  logic [7:0] m_byte;
  bit         chk_en = 0;

  always @(posedge Clk) begin
    s_rst  = Rst_n;
    s_wr   = a_wr_en;
    s_data = a_wr_data;
    s_baud = a_baud;
  end

  always @(negedge Clk) begin
    if (!s_rst) begin
      m_q.delete();
      m_in   = 0;
      m_cyc  = 0;
      m_done = 0;
      m_ovf  = 0;
    end else begin
      m_sz   = m_q.size();
      m_done = 0;
      m_ovf  = 0;
      if (m_in) begin
        m_cyc++;
        if (m_cyc == 10 * m_period) begin
          m_in   = 0;
          m_done = 1;
        end
      end
      if (!m_in && m_sz > 0) begin
        m_byte   = m_q.pop_front();
        m_bits   = {1'b1, m_byte, 1'b0};
        m_period = period_of(s_baud);
        m_cyc    = 0;
        m_in     = 1;
      end
      if (s_wr) begin
        if (m_sz == ADepth) m_ovf = 1;
        else m_q.push_back(s_data);
      end
    end
    if (chk_en) begin
      chk("model_tx", a_tx, m_in ? int'(m_bits[m_cyc / m_period]) : 1);
      chk("model_busy", a_busy, m_in);
      chk("model_done", a_done, m_done);
      chk("model_ovf", a_ovf, m_ovf);
      chk("model_level", a_level, m_q.size());
      chk("model_full", a_full, m_q.size() == ADepth);
    end
  end

  // ---------------- directed helpers ----------------
  task automatic write_a(input logic [7:0] d);
    a_wr_en   = 1'b1;
    a_wr_data = d;
    tick();
    a_wr_en   = 1'b0;
  endtask

  task automatic write_b(input logic [7:0] d);
    b_wr_en   = 1'b1;
    b_wr_data = d;
    tick();
    b_wr_en   = 1'b0;
  endtask

  // Called right after the edge that drove the start bit; samples each bit mid-period
  // and requires Tx_Done exactly nbits*period cycles after that edge.
  task automatic measure_frame(input bit sel, input string name, input logic [11:0] bits,
                               input int nbits, input int period);
    int n;
    int done_at;
    n = 0;
    done_at = -1;
    chk({name, "_start"}, line(sel), 0);
    while (done_at < 0 && n < nbits * period + 10) begin
      tick();
      n++;
      if (n < nbits * period && (n % period) == period / 2)
        chk(name, line(sel), int'(bits[n / period]));
      if (done(sel)) done_at = n;
    end
    chk({name, "_len"}, done_at, nbits * period);
  endtask

  typedef struct {
    logic [2:0] baud;
    logic [7:0] data;
    int         period;
  } vec_t;

  vec_t vecs[7];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int cnt_a;
    int cnt_b;

    vecs[0] = '{3'd4, 8'h7a, 10};
    vecs[1] = '{3'd0, 8'ha5, 120};
    vecs[2] = '{3'd1, 8'h3c, 60};
    vecs[3] = '{3'd2, 8'hff, 30};
    vecs[4] = '{3'd3, 8'h00, 20};
    vecs[5] = '{3'd7, 8'h81, 10};
    vecs[6] = '{3'd5, 8'h5a, 10};

    Rst_n = 1'b0;
    a_baud = 3'd4;  a_wr_en = 1'b0; a_wr_data = 8'h00;
    b_baud = 3'd4;  b_wr_en = 1'b0; b_wr_data = 8'h00;
    repeat (3) tick();
    chk_en = 1;
    chk("rst_tx", a_tx, 1);
    chk("rst_busy", a_busy, 0);
    chk("rst_done", a_done, 0);
    chk("rst_ovf", a_ovf, 0);
    chk("rst_full", a_full, 0);
    chk("rst_level", a_level, 0);
    chk("rst_b_tx", b_tx, 1);
    chk("rst_b_level", b_level, 0);
    Rst_n = 1'b1;
    tick();

    // Table-driven single frames across all baud selects.
    for (int i = 0; i < 7; i++) begin
      a_baud = vecs[i].baud;
      write_a(vecs[i].data);
      chk("pre_start_idle", a_tx, 1);
      tick();
      chk("start_latency", a_tx, 0);
      measure_frame(0, "table_bit", {2'b00, 1'b1, vecs[i].data, 1'b0}, 10, vecs[i].period);
      chk("table_busy_falls", a_busy, 0);
      tick();
    end

    // 18 consecutive writes into an idle 16-deep FIFO: 17 accepted, one dropped.
    a_baud = 3'd4;
    cnt_a = 0;
    cnt_b = 0;
    a_wr_en = 1'b1;
    for (int i = 0; i < 18; i++) begin
      a_wr_data = 8'(8'h40 + i);
      tick();
      cnt_a += int'(a_ovf);
    end
    a_wr_en = 1'b0;
    chk("ovf_full", a_full, 1);
    chk("ovf_level", a_level, 16);
    chk("ovf_pulse", a_ovf, 1);
    n = 0;
    while (a_busy && n < 3000) begin
      tick();
      n++;
      cnt_a += int'(a_ovf);
      cnt_b += int'(a_done);
    end
    chk("ovf_drain_cycles", n, 17 * 100 - 16);
    chk("ovf_pulses", cnt_a, 1);
    chk("ovf_frames", cnt_b, 17);
    tick();

    // Baud change during DATA affects only the next frame.
    a_baud = 3'd4;
    write_a(8'h11);
    write_a(8'h22);
    fork
      measure_frame(0, "baud_old", {3'b001, 8'h11, 1'b0}, 10, 10);
      begin
        repeat (20) tick();
        a_baud = 3'd0;
      end
    join
    measure_frame(0, "baud_new", {3'b001, 8'h22, 1'b0}, 10, 120);
    chk("baud_idle", a_busy, 0);
    a_baud = 3'd4;
    tick();

    // Reset during DATA with 5 bytes queued.
    a_wr_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      a_wr_data = 8'(i + 1);
      tick();
    end
    a_wr_en = 1'b0;
    repeat (13) tick();
    chk("rstmid_pre_level", a_level, 5);
    chk("rstmid_pre_busy", a_busy, 1);
    Rst_n = 1'b0;
    tick();
    Rst_n = 1'b1;
    chk("rstmid_tx", a_tx, 1);
    chk("rstmid_level", a_level, 0);
    chk("rstmid_busy", a_busy, 0);
    cnt_a = 0;
    cnt_b = 0;
    repeat (300) begin
      tick();
      cnt_a += int'(a_done);
      cnt_b += int'(!a_tx);
    end
    chk("rstmid_no_done", cnt_a, 0);
    chk("rstmid_no_frame", cnt_b, 0);

    // Write coinciding with the pop that chains the next frame, at level 3.
    write_a(8'hc1);
    write_a(8'hc2);
    write_a(8'hc3);
    write_a(8'hc4);
    chk("simul_level_before", a_level, 3);
    repeat (97) tick();
    a_wr_en   = 1'b1;
    a_wr_data = 8'hc5;
    tick();
    a_wr_en   = 1'b0;
    chk("simul_level", a_level, 3);
    chk("simul_done_same_edge", a_done, 1);
    chk("simul_next_start", a_tx, 0);
    n = 0;
    while (a_busy && n < 1000) begin
      tick();
      n++;
    end
    chk("simul_drain_cycles", n, 400);
    tick();

    // Random traffic with run-time baud changes; the model checks every cycle.
    for (int i = 0; i < 3000; i++) begin
      a_wr_en   = ($urandom_range(0, 5) == 0);
      a_wr_data = 8'($urandom);
      if ($urandom_range(0, 49) == 0) a_baud = 3'($urandom_range(2, 7));
      tick();
    end
    a_wr_en = 1'b0;
    n = 0;
    while ((a_busy || a_level != 0) && n < 8000) begin
      tick();
      n++;
    end
    chk("rand_drained", int'(a_busy || a_level != 0), 0);

    // Odd parity, two stop bits at 50 MHz / 115200: 434 cycles per bit, 12 bits.
    write_b(8'h03);
    chk("par_pre_start", b_tx, 1);
    tick();
    chk("par_start_latency", b_tx, 0);
    measure_frame(1, "par_bit", 12'b1110_0000_0110, 12, 434);
    chk("par_busy_falls", b_busy, 0);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
